// File: rtl/controle_aquecedor_pkg.sv
// Shared state encoding for the heater controller FSM and its debug display.
package controle_aquecedor_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    AQUECENDO = 3'd1,
    MANTENDO  = 3'd2,
    FIM       = 3'd3,
    ERRO      = 3'd4
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear and enable; fim marks the terminal count.
module contador_m #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (zera)
      q <= '0;
    else if (conta)
      q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
  end

  assign fim = conta && (q == N'(M - 1));

endmodule

// File: rtl/controle_aquecedor.sv
// Heater controller: boil or keep-warm with hysteresis, seconds timeout,
// cancellation and a sticky error state. All outputs decoded from next state.
module controle_aquecedor
  import controle_aquecedor_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int TIMEOUT_S = 120,
  parameter int MANTER_S  = 30,
  parameter int W_SEG     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             liga,
  input  logic             cancela,
  input  logic             modo,
  input  logic             fim_temperatura,
  input  logic             abaixo_minimo,
  output logic             ebulidor,
  output logic             fim_ebulidor,
  output logic             timeout,
  output logic             ocupado,
  output logic [W_SEG-1:0] segundos,
  output logic [2:0]       db_estado
);

  estado_t          estado, prox;
  logic             modo_lat;
  logic             tick, conta, limpa, latch_modo, ebul_prox;
  logic [W_SEG-1:0] segundos_inc;

  assign conta        = (estado == AQUECENDO) || (estado == MANTENDO);
  assign segundos_inc = (segundos == '1) ? segundos : segundos + 1'b1;

  contador_m #(
    .M(CLK_HZ),
    .N($clog2(CLK_HZ))
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .zera  (limpa),
    .conta (conta),
    .fim   (tick)
  );

  // Transition logic; limpa restarts the prescaler and seconds on every timed-state entry
  always_comb begin
    prox       = estado;
    limpa      = 1'b0;
    latch_modo = 1'b0;
    ebul_prox  = 1'b0;
    case (estado)
      OCIOSO, ERRO: begin
        if (cancela)
          prox = OCIOSO;
        else if (liga) begin
          prox       = AQUECENDO;
          limpa      = 1'b1;
          latch_modo = 1'b1;
        end
      end
      AQUECENDO: begin
        if (cancela)
          prox = OCIOSO;
        else if (fim_temperatura) begin
          if (modo_lat) begin
            prox  = MANTENDO;
            limpa = 1'b1;
          end else
            prox = FIM;
        end else if (tick && (segundos_inc == W_SEG'(TIMEOUT_S)))
          prox = ERRO;
      end
      MANTENDO: begin
        if (cancela)
          prox = OCIOSO;
        else if (tick && (segundos_inc == W_SEG'(MANTER_S)))
          prox = FIM;
      end
      default: prox = OCIOSO;
    endcase

    case (prox)
      AQUECENDO: ebul_prox = 1'b1;
      MANTENDO: begin
        if (estado != MANTENDO)
          ebul_prox = 1'b0;
        else if (fim_temperatura)
          ebul_prox = 1'b0;
        else if (abaixo_minimo)
          ebul_prox = 1'b1;
        else
          ebul_prox = ebulidor;
      end
      default: ebul_prox = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      modo_lat     <= 1'b0;
      segundos     <= '0;
      ebulidor     <= 1'b0;
      fim_ebulidor <= 1'b0;
      timeout      <= 1'b0;
      ocupado      <= 1'b0;
      db_estado    <= 3'd0;
    end else begin
      estado       <= prox;
      ebulidor     <= ebul_prox;
      fim_ebulidor <= (prox == FIM);
      timeout      <= (prox == ERRO);
      ocupado      <= (prox == AQUECENDO) || (prox == MANTENDO);
      db_estado    <= prox;
      if (latch_modo)
        modo_lat <= modo;
      if (limpa)
        segundos <= '0;
      else if (tick)
        segundos <= segundos_inc;
    end
  end

endmodule

// File: tb/tb_controle_aquecedor.sv
// Directed bench for controle_aquecedor with CLK_HZ=10, TIMEOUT_S=3, MANTER_S=2.
module tb_controle_aquecedor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       liga = 1'b0, cancela = 1'b0, modo = 1'b0;
  logic       fim_temperatura = 1'b0, abaixo_minimo = 1'b0;
  logic       ebulidor, fim_ebulidor, timeout, ocupado;
  logic [3:0] segundos;
  logic [2:0] db_estado;
  logic [6:0] saidas;
  int         checks = 0;
  int         errors = 0;

  // {ebulidor, fim_ebulidor, timeout, ocupado, db_estado}
  assign saidas = {ebulidor, fim_ebulidor, timeout, ocupado, db_estado};

  localparam logic [6:0] S_OCIOSO = 7'b0000_000;
  localparam logic [6:0] S_AQ     = 7'b1001_001;
  localparam logic [6:0] S_MAN0   = 7'b0001_010;
  localparam logic [6:0] S_MAN1   = 7'b1001_010;
  localparam logic [6:0] S_FIM    = 7'b0100_011;
  localparam logic [6:0] S_ERRO   = 7'b0010_100;

  controle_aquecedor #(
    .CLK_HZ(10), .TIMEOUT_S(3), .MANTER_S(2), .W_SEG(4)
  ) dut (
    .clock(clock), .reset(reset), .liga(liga), .cancela(cancela), .modo(modo),
    .fim_temperatura(fim_temperatura), .abaixo_minimo(abaixo_minimo),
    .ebulidor(ebulidor), .fim_ebulidor(fim_ebulidor), .timeout(timeout),
    .ocupado(ocupado), .segundos(segundos), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({saidas, segundos} !== {S_OCIOSO, 4'd0}) begin
      errors++; $display("[TB] FAIL reset_outputs got %b/%0d exp %b/0", saidas, segundos, S_OCIOSO);
    end
    reset = 1'b1;
    step();
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL reset_idle got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  task automatic test_ferver();
    modo = 1'b0; liga = 1'b1;
    step();
    liga = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (saidas !== S_AQ) begin
        errors++; $display("[TB] FAIL ferver_heating c%0d got %b exp %b", c, saidas, S_AQ);
      end
      if (c < 11) step();
    end
    fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0;
    checks++;
    if ({saidas, segundos} !== {S_FIM, 4'd1}) begin
      errors++; $display("[TB] FAIL ferver_fim got %b/%0d exp %b/1", saidas, segundos, S_FIM);
    end
    step();
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL ferver_back_idle got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  task automatic test_timeout();
    modo = 1'b0; liga = 1'b1;
    step();
    liga = 1'b0;
    repeat (29) step();
    checks++;
    if ({saidas, segundos} !== {S_AQ, 4'd2}) begin
      errors++; $display("[TB] FAIL timeout_pre got %b/%0d exp %b/2", saidas, segundos, S_AQ);
    end
    step();
    checks++;
    if ({saidas, segundos} !== {S_ERRO, 4'd3}) begin
      errors++; $display("[TB] FAIL timeout_erro got %b/%0d exp %b/3", saidas, segundos, S_ERRO);
    end
    repeat (5) step();
    checks++;
    if ({saidas, segundos} !== {S_ERRO, 4'd3}) begin
      errors++; $display("[TB] FAIL timeout_sticky got %b/%0d exp %b/3", saidas, segundos, S_ERRO);
    end
    liga = 1'b1;
    step();
    liga = 1'b0;
    checks++;
    if ({saidas, segundos} !== {S_AQ, 4'd0}) begin
      errors++; $display("[TB] FAIL timeout_relig got %b/%0d exp %b/0", saidas, segundos, S_AQ);
    end
    cancela = 1'b1;
    step();
    cancela = 1'b0;
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL timeout_cancel got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  task automatic test_manter();
    logic [6:0] esperado;
    modo = 1'b1; liga = 1'b1;
    step();
    liga = 1'b0; modo = 1'b0;
    repeat (3) step();
    fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0;
    checks++;
    if ({saidas, segundos} !== {S_MAN0, 4'd0}) begin
      errors++; $display("[TB] FAIL manter_entry got %b/%0d exp %b/0", saidas, segundos, S_MAN0);
    end
    for (int c = 6; c <= 25; c++) begin
      abaixo_minimo   = (c == 10) || (c == 17);
      fim_temperatura = (c == 14);
      step();
      if (c == 25)
        esperado = S_FIM;
      else if ((c >= 10 && c <= 13) || (c >= 17))
        esperado = S_MAN1;
      else
        esperado = S_MAN0;
      checks++;
      if (saidas !== esperado) begin
        errors++; $display("[TB] FAIL manter_cycle c%0d got %b exp %b", c, saidas, esperado);
      end
    end
    abaixo_minimo = 1'b0; fim_temperatura = 1'b0;
    checks++;
    if (segundos !== 4'd2) begin
      errors++; $display("[TB] FAIL manter_segundos got %0d exp 2", segundos);
    end
    step();
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL manter_idle got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  task automatic test_liga_ocupado();
    modo = 1'b0; liga = 1'b1;
    step();
    modo = 1'b1;
    repeat (12) step();
    liga = 1'b0;
    checks++;
    if ({saidas, segundos} !== {S_AQ, 4'd1}) begin
      errors++; $display("[TB] FAIL busy_ignore got %b/%0d exp %b/1", saidas, segundos, S_AQ);
    end
    fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0; modo = 1'b0;
    checks++;
    if (saidas !== S_FIM) begin
      errors++; $display("[TB] FAIL busy_modo_kept got %b exp %b", saidas, S_FIM);
    end
    step();
  endtask

  task automatic test_simultaneo();
    modo = 1'b0; liga = 1'b1;
    step();
    liga = 1'b0;
    repeat (29) step();
    fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0;
    checks++;
    if (saidas !== S_FIM) begin
      errors++; $display("[TB] FAIL simult_temp_wins got %b exp %b", saidas, S_FIM);
    end
    step();
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL simult_idle got %b exp %b", saidas, S_OCIOSO);
    end
    modo = 1'b1; liga = 1'b1;
    step();
    liga = 1'b0; fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0; abaixo_minimo = 1'b1;
    step();
    checks++;
    if (saidas !== S_MAN1) begin
      errors++; $display("[TB] FAIL hyst_set got %b exp %b", saidas, S_MAN1);
    end
    fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0; abaixo_minimo = 1'b0;
    checks++;
    if (saidas !== S_MAN0) begin
      errors++; $display("[TB] FAIL hyst_both_clear got %b exp %b", saidas, S_MAN0);
    end
    cancela = 1'b1;
    step();
    cancela = 1'b0;
  endtask

  task automatic test_cancela();
    modo = 1'b1; liga = 1'b1;
    step();
    liga = 1'b0; fim_temperatura = 1'b1;
    step();
    fim_temperatura = 1'b0; abaixo_minimo = 1'b1;
    step();
    abaixo_minimo = 1'b0; cancela = 1'b1;
    step();
    cancela = 1'b0;
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL cancel_manter got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  task automatic test_reset_assincrono();
    modo = 1'b0; liga = 1'b1;
    step();
    liga = 1'b0;
    repeat (3) step();
    checks++;
    if (saidas !== S_AQ) begin
      errors++; $display("[TB] FAIL areset_pre got %b exp %b", saidas, S_AQ);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({saidas, segundos} !== {S_OCIOSO, 4'd0}) begin
      errors++; $display("[TB] FAIL areset_async got %b/%0d exp %b/0", saidas, segundos, S_OCIOSO);
    end
    reset = 1'b1;
    step();
    checks++;
    if (saidas !== S_OCIOSO) begin
      errors++; $display("[TB] FAIL areset_release got %b exp %b", saidas, S_OCIOSO);
    end
  endtask

  initial begin
    test_reset();
    test_ferver();
    test_timeout();
    test_manter();
    test_liga_ocupado();
    test_simultaneo();
    test_cancela();
    test_reset_assincrono();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
